// File: rtl/seq_sub_64_if.sv
// Handshake and operand/result bundle for the sequential 64-bit subtractor.
interface seq_sub_64_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;

    // Producer/consumer side: drives operands and accepts results.
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    // Subtractor side.
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );
endinterface

// File: rtl/seq_sub_64.sv
// Sequential 64-bit subtractor: computes a - b - bin one CHUNK_W slice per cycle,
// LSB slice first, rippling the borrow through a register between slices.
module seq_sub_64 #(
    parameter int unsigned CHUNK_W = 16
) (
    input logic         clk,
    input logic         rst,
    seq_sub_64_if.slave bus
);
    localparam int unsigned N       = 64 / CHUNK_W;
    localparam int unsigned CntW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [63:0]     a_q;
    logic [63:0]     b_q;
    logic [63:0]     acc_q;
    logic            brw_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [63:0]     diff_q;
    logic            bout_q;
    logic            zero_q;
    logic            ovf_q;

    logic [CHUNK_W-1:0] a_sl;
    logic [CHUNK_W-1:0] b_sl;
    logic [CHUNK_W-1:0] d_sl;
    logic [CHUNK_W:0]   sum;
    logic               brw_d;
    logic [63:0]        acc_d;

    // One slice of subtraction: a + ~b + ~borrow, borrow-out is the inverted carry.
    always_comb begin
        a_sl  = a_q[CHUNK_W-1:0];
        b_sl  = b_q[CHUNK_W-1:0];
        sum   = {1'b0, a_sl} + {1'b0, ~b_sl} + {{CHUNK_W{1'b0}}, ~brw_q};
        d_sl  = sum[CHUNK_W-1:0];
        brw_d = ~sum[CHUNK_W];
        // New slice enters at the top; after N slices the LSB slice sits at bit 0.
        acc_d = {d_sl, acc_q[63:CHUNK_W]};
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            brw_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        brw_q      <= bus.bin;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StCalc;
                    end
                end
                StCalc: begin
                    a_q   <= a_q >> CHUNK_W;
                    b_q   <= b_q >> CHUNK_W;
                    brw_q <= brw_d;
                    acc_q <= acc_d;
                    if (cnt_q == CntLast) begin
                        cnt_q       <= '0;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        diff_q      <= acc_d;
                        bout_q      <= brw_d;
                        zero_q      <= (acc_d == 64'd0);
                        // The last slice carries the sign bits of a, b and diff.
                        ovf_q       <= (a_sl[CHUNK_W-1] != b_sl[CHUNK_W-1]) &&
                                       (d_sl[CHUNK_W-1] != a_sl[CHUNK_W-1]);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_sub_64.sv
// Bench for seq_sub_64: three instances (CHUNK_W = 16, 8, 32) driven in lockstep.
module tb_seq_sub_64;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    seq_sub_64_if if16 ();
    seq_sub_64_if if8 ();
    seq_sub_64_if if32 ();

    seq_sub_64 #(.CHUNK_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    seq_sub_64 #(.CHUNK_W(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8));
    seq_sub_64 #(.CHUNK_W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32));

    localparam int Lat[3] = '{4, 8, 2};
    localparam int Wid[3] = '{16, 8, 32};

    logic        vld[3];
    logic        rdy[3];
    logic [63:0] r_diff[3];
    logic        r_bout[3];
    logic        r_zero[3];
    logic        r_ovf[3];

    assign vld[0] = if16.out_valid;  assign vld[1] = if8.out_valid;  assign vld[2] = if32.out_valid;
    assign rdy[0] = if16.in_ready;   assign rdy[1] = if8.in_ready;   assign rdy[2] = if32.in_ready;
    assign r_diff[0] = if16.diff;    assign r_diff[1] = if8.diff;    assign r_diff[2] = if32.diff;
    assign r_bout[0] = if16.bout;    assign r_bout[1] = if8.bout;    assign r_bout[2] = if32.bout;
    assign r_zero[0] = if16.zero;    assign r_zero[1] = if8.zero;    assign r_zero[2] = if32.zero;
    assign r_ovf[0]  = if16.ovf;     assign r_ovf[1]  = if8.ovf;     assign r_ovf[2]  = if32.ovf;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [63:0] d;
        logic        bo;
        logic        z;
        logic        o;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: plain 65-bit arithmetic; a negative result means a borrow out.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic bin,
                         output logic [63:0] d, output logic bo, output logic z,
                         output logic o);
        logic [64:0] f;
        f  = {1'b0, a} - {1'b0, b} - {64'd0, bin};
        d  = f[63:0];
        bo = f[64];
        z  = (d == 64'd0);
        o  = (a[63] != b[63]) && (d[63] != a[63]);
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b,
                         input logic bin);
        if16.in_valid = v; if16.a = a; if16.b = b; if16.bin = bin;
        if8.in_valid  = v; if8.a  = a; if8.b  = b; if8.bin  = bin;
        if32.in_valid = v; if32.a = a; if32.b = b; if32.bin = bin;
    endtask

    task automatic set_ordy(input logic r);
        if16.out_ready = r;
        if8.out_ready  = r;
        if32.out_ready = r;
    endtask

    // Accept an op on all instances and wait (bounded) for every out_valid.
    task automatic start_wait(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input logic bin, input bit junk);
        int lat[3];
        bit done;
        lat = '{-1, -1, -1};
        done = 1'b0;
        for (int i = 0; i < 3; i++) chk($sformatf("%s w%0d in_ready", tag, Wid[i]), 64'(rdy[i]), 64'd1);
        drive(1'b1, a, b, bin);
        @(negedge clk);
        for (int k = 1; k <= 40 && !done; k++) begin
            if (junk) drive(1'($urandom_range(1, 0)), {$urandom, $urandom}, {$urandom, $urandom},
                            1'($urandom_range(1, 0)));
            else drive(1'b0, 64'd0, 64'd0, 1'b0);
            @(negedge clk);
            done = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (vld[i] && lat[i] < 0) lat[i] = k;
                if (lat[i] < 0) done = 1'b0;
            end
        end
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) chk($sformatf("%s w%0d latency", tag, Wid[i]), 64'(lat[i]), 64'(Lat[i]));
    endtask

    task automatic chk_res(input string tag, input logic [63:0] ed, input logic eb,
                           input logic ez, input logic eo);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s w%0d diff", tag, Wid[i]), r_diff[i], ed);
            chk($sformatf("%s w%0d bout", tag, Wid[i]), 64'(r_bout[i]), 64'(eb));
            chk($sformatf("%s w%0d zero", tag, Wid[i]), 64'(r_zero[i]), 64'(ez));
            chk($sformatf("%s w%0d ovf", tag, Wid[i]), 64'(r_ovf[i]), 64'(eo));
        end
    endtask

    task automatic handshake(input string tag);
        set_ordy(1'b1);
        @(negedge clk);
        set_ordy(1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s w%0d out_valid after hs", tag, Wid[i]), 64'(vld[i]), 64'd0);
            chk($sformatf("%s w%0d in_ready after hs", tag, Wid[i]), 64'(rdy[i]), 64'd1);
        end
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic bin, input logic [63:0] ed, input logic eb,
                          input logic ez, input logic eo, input bit junk);
        start_wait(tag, a, b, bin, junk);
        chk_res(tag, ed, eb, ez, eo);
        handshake(tag);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [63:0] ra, rb, ed;
        logic        rbin, eb, ez, eo;
        int          seen;

        tbl[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'd0, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                   64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{64'd1, 64'd0, 1'b1, 64'd0, 1'b0, 1'b1, 1'b0};

        drive(1'b0, 64'd0, 64'd0, 1'b0);
        set_ordy(1'b0);
        repeat (3) @(negedge clk);
        // in_valid on a reset edge must not be accepted.
        drive(1'b1, 64'd9, 64'd1, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset w%0d in_ready", Wid[i]), 64'(rdy[i]), 64'd1);
            chk($sformatf("reset w%0d out_valid", Wid[i]), 64'(vld[i]), 64'd0);
            chk($sformatf("reset w%0d diff", Wid[i]), r_diff[i], 64'd0);
            chk($sformatf("reset w%0d flags", Wid[i]), {61'd0, r_bout[i], r_zero[i], r_ovf[i]}, 64'd0);
        end
        rst = 1'b0;
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk($sformatf("post-reset w%0d in_ready", Wid[i]), 64'(rdy[i]), 64'd1);

        for (int t = 0; t < 6; t++)
            run_op($sformatf("vec%0d", t), tbl[t].a, tbl[t].b, tbl[t].bin,
                   tbl[t].d, tbl[t].bo, tbl[t].z, tbl[t].o, 1'b0);

        // Hold in DONE while in_valid pulses with other operands.
        model(64'd100, 64'd1, 1'b0, ed, eb, ez, eo);
        start_wait("hold", 64'd100, 64'd1, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 64'd7, 64'd9, 1'b0);
            @(negedge clk);
            chk_res($sformatf("hold c%0d", c), ed, eb, ez, eo);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("hold c%0d w%0d in_ready", c, Wid[i]), 64'(rdy[i]), 64'd0);
                chk($sformatf("hold c%0d w%0d out_valid", c, Wid[i]), 64'(vld[i]), 64'd1);
            end
        end
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        handshake("hold");
        model(64'd7, 64'd9, 1'b0, ed, eb, ez, eo);
        run_op("after-hold", 64'd7, 64'd9, 1'b0, ed, eb, ez, eo, 1'b0);

        // Reset on the edge ending the second CALC cycle aborts the op.
        drive(1'b1, 64'd50, 64'd20, 1'b0);
        @(negedge clk);
        drive(1'b0, 64'd0, 64'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("abort w%0d out_valid", Wid[i]), 64'(vld[i]), 64'd0);
            chk($sformatf("abort w%0d in_ready", Wid[i]), 64'(rdy[i]), 64'd1);
            chk($sformatf("abort w%0d diff", Wid[i]), r_diff[i], 64'd0);
            chk($sformatf("abort w%0d flags", Wid[i]), {61'd0, r_bout[i], r_zero[i], r_ovf[i]}, 64'd0);
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (vld[i]) seen++;
        end
        chk("abort no out_valid", 64'(seen), 64'd0);
        run_op("after-abort", 64'd10, 64'd4, 1'b0, 64'd6, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized ops with junk on in_valid/operands while busy.
        for (int n = 0; n < 40; n++) begin
            ra   = {$urandom, $urandom};
            rb   = {$urandom, $urandom};
            rbin = 1'($urandom_range(1, 0));
            case ($urandom_range(3, 0))
                0: ;
                1: rb = ra;
                2: ra = 64'($urandom_range(3, 0));
                default: ra = {ra[63], 31'd0, $urandom_range(1, 0) == 1 ? 32'hFFFF_FFFF : 32'd0};
            endcase
            model(ra, rb, rbin, ed, eb, ez, eo);
            run_op($sformatf("rnd%0d", n), ra, rb, rbin, ed, eb, ez, eo, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
